// File: rtl/fetch_pc_if.sv
// Bundles the branch-resolution, instruction-memory and decode channels seen by fetch_pc_unit.
// The master modport is the fetch unit's side. The slave modport is the surrounding pipeline and memory.
interface fetch_pc_if;
    logic        br_valid;
    logic        br_taken;
    logic        br_is_jump;
    logic        br_is_jalr;
    logic [31:0] br_pc;
    logic [31:0] br_imm;
    logic [31:0] br_rs1;

    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;

    logic        flush;
    logic        misalign_trap;
    logic [31:0] misalign_addr;

    modport master (
        input  br_valid, br_taken, br_is_jump, br_is_jalr, br_pc, br_imm, br_rs1,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output if_valid, if_instr, if_pc,
        input  if_ready,
        output flush, misalign_trap, misalign_addr
    );

    modport slave (
        output br_valid, br_taken, br_is_jump, br_is_jalr, br_pc, br_imm, br_rs1,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  if_valid, if_instr, if_pc,
        output if_ready,
        input  flush, misalign_trap, misalign_addr
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch PC unit: one outstanding imem request, single-entry hold buffer toward decode,
// branch/jump redirect with a one-cycle flush, and a sticky trap on misaligned redirect targets.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    fetch_pc_if.master bus
);
    typedef enum logic [1:0] {FETCH, WAIT, HOLD, TRAP} state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] req_pc_reg, req_pc_next;
    logic        kill_reg, kill_next;
    logic [31:0] if_instr_reg, if_instr_next;
    logic [31:0] if_pc_reg, if_pc_next;
    logic        flush_reg, flush_next;
    logic        trap_reg, trap_next;
    logic [31:0] misalign_addr_reg, misalign_addr_next;

    logic [31:0] target;
    logic        redirect;

    // JALR drops bit 0 of the sum. Bit 1 is left in place so that the misalignment check can see it.
    always_comb begin
        if (bus.br_is_jalr) begin
            target = (bus.br_rs1 + bus.br_imm) & 32'hFFFF_FFFE;
        end else begin
            target = bus.br_pc + bus.br_imm;
        end
    end

    assign redirect = bus.br_valid && (bus.br_is_jump || bus.br_taken) && (state_reg != TRAP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= FETCH;
            pc_reg            <= RESET_PC;
            req_pc_reg        <= 32'h0;
            kill_reg          <= 1'b0;
            if_instr_reg      <= 32'h0;
            if_pc_reg         <= 32'h0;
            flush_reg         <= 1'b0;
            trap_reg          <= 1'b0;
            misalign_addr_reg <= 32'h0;
        end else begin
            state_reg         <= state_next;
            pc_reg            <= pc_next;
            req_pc_reg        <= req_pc_next;
            kill_reg          <= kill_next;
            if_instr_reg      <= if_instr_next;
            if_pc_reg         <= if_pc_next;
            flush_reg         <= flush_next;
            trap_reg          <= trap_next;
            misalign_addr_reg <= misalign_addr_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        pc_next            = pc_reg;
        req_pc_next        = req_pc_reg;
        kill_next          = kill_reg;
        if_instr_next      = if_instr_reg;
        if_pc_next         = if_pc_reg;
        flush_next         = 1'b0;
        trap_next          = trap_reg;
        misalign_addr_next = misalign_addr_reg;

        if (redirect && (target[1:0] != 2'b00)) begin
            state_next         = TRAP;
            trap_next          = 1'b1;
            misalign_addr_next = target;
            flush_next         = 1'b1;
            kill_next          = 1'b0;
            if_instr_next      = 32'h0;
            if_pc_next         = 32'h0;
        end else if (redirect) begin
            pc_next    = target;
            flush_next = 1'b1;
            unique case (state_reg)
                FETCH: begin
                    // A request accepted in this cycle is already in flight, so its response must be dropped.
                    if (bus.imem_req_ready) begin
                        state_next = WAIT;
                        kill_next  = 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        state_next = FETCH;
                        kill_next  = 1'b0;
                    end else begin
                        kill_next = 1'b1;
                    end
                end
                HOLD:    state_next = FETCH;
                default: state_next = state_reg;
            endcase
        end else begin
            unique case (state_reg)
                FETCH: begin
                    if (bus.imem_req_ready) begin
                        req_pc_next = pc_reg;
                        pc_next     = pc_reg + 32'd4;
                        state_next  = WAIT;
                    end
                end
                WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        if (kill_reg) begin
                            kill_next  = 1'b0;
                            state_next = FETCH;
                        end else begin
                            if_instr_next = bus.imem_rsp_data;
                            if_pc_next    = req_pc_reg;
                            state_next    = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.if_ready) state_next = FETCH;
                end
                default: state_next = state_reg;
            endcase
        end
    end

    assign bus.imem_req_valid = (state_reg == FETCH) && !rst;
    assign bus.imem_req_addr  = (state_reg == TRAP) ? 32'h0 : pc_reg;
    assign bus.if_valid       = (state_reg == HOLD);
    assign bus.if_instr       = if_instr_reg;
    assign bus.if_pc          = if_pc_reg;
    assign bus.flush          = flush_reg;
    assign bus.misalign_trap  = trap_reg;
    assign bus.misalign_addr  = misalign_addr_reg;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Random-stimulus bench for fetch_pc_unit. A transaction-level model tracks the outstanding request,
// the held instruction and the trap. The bench also acts as a variable-latency instruction memory.
module tb_fetch_pc_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          N_CYC  = 4000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_pc_if bus();

    fetch_pc_unit #(.RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state, expressed as transactions rather than FSM states.
    logic [31:0] m_pc = RST_PC;
    logic        m_out = 1'b0;     // request in flight
    logic        m_kill = 1'b0;    // in-flight request already doomed
    logic [31:0] m_out_pc = 32'h0;
    logic        m_held = 1'b0;    // instruction waiting for decode
    logic [31:0] m_ifi = 32'h0;
    logic [31:0] m_ifp = 32'h0;
    logic        m_flush = 1'b0;
    logic        m_trap = 1'b0;
    logic [31:0] m_maddr = 32'h0;

    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;
    int          trap_age = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
    endfunction

    task automatic model_step();
        logic        hs;
        logic        redir;
        logic [31:0] tgt;
        if (rst) begin
            m_pc = RST_PC; m_out = 0; m_kill = 0; m_out_pc = 0; m_held = 0;
            m_ifi = 0; m_ifp = 0; m_flush = 0; m_trap = 0; m_maddr = 0;
            return;
        end
        hs = !m_trap && !m_out && !m_held && bus.imem_req_ready;
        if (hs) begin
            mem_cnt  = $urandom_range(1, 3);
            mem_addr = m_pc;
        end
        if (m_held && bus.if_ready)
            $display("decode accepts pc=%h instr=%h", m_ifp, m_ifi);
        tgt   = bus.br_is_jalr ? ((bus.br_rs1 + bus.br_imm) & ~32'h1) : (bus.br_pc + bus.br_imm);
        redir = !m_trap && bus.br_valid && (bus.br_is_jump || bus.br_taken);
        m_flush = redir;
        if (redir && (tgt % 4 != 0)) begin
            m_trap = 1; m_maddr = tgt; m_held = 0; m_out = 0; m_kill = 0;
            m_ifi = 0; m_ifp = 0;
        end else if (redir) begin
            if (hs) begin
                m_out = 1; m_kill = 1;
            end else if (m_out) begin
                if (bus.imem_rsp_valid) begin m_out = 0; m_kill = 0; end
                else m_kill = 1;
            end else begin
                m_held = 0;
            end
            m_pc = tgt;
        end else if (hs) begin
            m_out = 1; m_kill = 0; m_out_pc = m_pc; m_pc = m_pc + 4;
        end else if (m_out && bus.imem_rsp_valid) begin
            m_out = 0;
            if (!m_kill) begin
                m_held = 1; m_ifi = bus.imem_rsp_data; m_ifp = m_out_pc;
            end
            m_kill = 0;
        end else if (m_held && bus.if_ready) begin
            m_held = 0;
        end
    endtask

    task automatic mem_advance();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = $urandom;
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem_word(mem_addr);
            end
        end
    endtask

    task automatic set_inputs(input int cyc);
        logic [31:0] imm;
        logic        misal;
        if (cyc < 3)                      rst = 1'b1;
        else if (m_trap && trap_age > 4)  rst = 1'b1;
        else                              rst = ($urandom_range(0, 199) == 0);
        bus.imem_req_ready = (mem_cnt == 0) && ($urandom_range(0, 3) != 0);
        bus.if_ready       = ($urandom_range(0, 2) != 0);

        misal = ($urandom_range(0, 15) == 0);
        imm   = 32'(($urandom_range(0, 255) << 2)) - 32'd512;
        if (misal) imm = imm | 32'($urandom_range(1, 3));
        bus.br_valid   = ($urandom_range(0, 9) == 0);
        bus.br_taken   = $urandom_range(0, 1) != 0;
        bus.br_is_jump = ($urandom_range(0, 3) == 0);
        bus.br_is_jalr = bus.br_is_jump && ($urandom_range(0, 1) != 0);
        bus.br_pc      = $urandom & ~32'h3;
        bus.br_imm     = imm;
        bus.br_rs1     = ($urandom & ~32'h3) | 32'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) begin
            bus.br_pc  = 32'hFFFF_FFF0;
            bus.br_imm = misal ? 32'hD : 32'hC;
        end

        // Directed redirects from the bring-up plan, interleaved with the random traffic.
        if (cyc == 20 || cyc == 40 || cyc == 60 || cyc == 80) begin
            rst = 1'b0; bus.br_valid = 1'b1; bus.br_taken = 1'b1;
            bus.br_is_jump = 1'b0; bus.br_is_jalr = 1'b0;
        end
        if (cyc == 20) begin bus.br_pc = 32'h200; bus.br_imm = 32'h40; end
        if (cyc == 40) begin
            bus.br_is_jump = 1'b1; bus.br_is_jalr = 1'b1;
            bus.br_rs1 = 32'h1001; bus.br_imm = 32'h0;
        end
        if (cyc == 60) begin bus.br_is_jump = 1'b1; bus.br_pc = 32'hFFFF_FFF0; bus.br_imm = 32'hC; end
        if (cyc == 80) begin bus.br_pc = 32'h300; bus.br_imm = 32'h6; end
    endtask

    task automatic check_outputs();
        logic exp_rv;
        exp_rv = !rst && !m_trap && !m_out && !m_held;
        check_eq("imem_req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
        if (exp_rv) check_eq("imem_req_addr", bus.imem_req_addr, m_pc);
        check_eq("if_valid", 32'(bus.if_valid), 32'(m_held));
        if (m_held || m_trap) begin
            check_eq("if_instr", bus.if_instr, m_ifi);
            check_eq("if_pc", bus.if_pc, m_ifp);
        end
        check_eq("flush", 32'(bus.flush), 32'(m_flush));
        check_eq("misalign_trap", 32'(bus.misalign_trap), 32'(m_trap));
        check_eq("misalign_addr", bus.misalign_addr, m_maddr);
    endtask

    initial begin
        rst = 1'b1;
        bus.br_valid = 0; bus.br_taken = 0; bus.br_is_jump = 0; bus.br_is_jalr = 0;
        bus.br_pc = 0; bus.br_imm = 0; bus.br_rs1 = 0;
        bus.imem_req_ready = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = 0;
        bus.if_ready = 0;
        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            set_inputs(cyc);
            #1;
            if (cyc >= 1) check_outputs();
            model_step();
            @(posedge clk);
            #1;
            mem_advance();
            trap_age = m_trap ? trap_age + 1 : 0;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
